// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
// Holds the default operand width, the product width derived from it,
// and the controller state encoding used by seq_mult_responder.
package seq_mult_pkg;

  localparam int WIDTH_DEFAULT  = 4;
  localparam int PROD_W_DEFAULT = 2 * WIDTH_DEFAULT;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Product width for a given operand width.
  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/seq_mult_responder.sv
// Iterative shift-and-add unsigned multiplier with valid/ready handshakes.
// An operand pair is accepted in IDLE, the product is built over exactly
// WIDTH enabled cycles in RUN, and is then offered in DONE until taken.
//
// Ports:
//   clk       - system clock, rising edge
//   rst       - synchronous active-high reset (wins over ena)
//   ena       - design enable; 0 freezes all state and blocks handshakes
//   in_valid  - host presents operands a/b
//   in_ready  - core can accept operands (IDLE, enabled, not in reset)
//   a, b      - unsigned multiplicand / multiplier, WIDTH bits
//   out_valid - product available (DONE, enabled, not in reset)
//   out_ready - host takes the product
//   product   - last completed result, 2*WIDTH bits (0 after reset)
//   busy      - high in RUN or DONE
module seq_mult_responder
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ena,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            a,
  input  logic [WIDTH-1:0]            b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [prod_w(WIDTH)-1:0]    product,
  output logic                        busy
);

  localparam int PW = prod_w(WIDTH);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  state_e          state_q,   state_d;
  logic [CW-1:0]   count_q,   count_d;
  logic [PW-1:0]   acc_q,     acc_d;
  logic [PW-1:0]   mcand_q,   mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]   product_q, product_d;

  // Next-state and datapath update; everything holds when ena is low.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    product_d = product_q;
    if (ena) begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            count_d  = '0;
            state_d  = RUN;
          end else begin
            state_d  = IDLE;
          end
        end
        RUN: begin
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end else begin
            acc_d = acc_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          count_d  = count_q + CW'(1);
          // Fixed-length run: no early exit when the multiplier empties.
          if (count_q == LAST_COUNT) begin
            state_d   = DONE;
            product_d = acc_d;
          end else begin
            state_d   = RUN;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end else begin
            state_d = DONE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      product_q <= product_d;
    end
  end

  // Handshake strobes are gated so nothing can complete while frozen or in reset.
  assign in_ready  = ena & ~rst & (state_q == IDLE);
  assign out_valid = ena & ~rst & (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign product   = product_q;

endmodule

// File: tb/tb_seq_mult_responder.sv
`timescale 1ns/1ps
module tb_seq_mult_responder;
  import seq_mult_pkg::*;

  localparam int W = WIDTH_DEFAULT;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           ena = 1'b1;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           in_ready;
  logic           out_valid;
  logic           busy;
  logic [2*W-1:0] product;

  int total = 0;
  int bad = 0;

  seq_mult_responder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int expv);
    total++;
    if (got != expv) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, expv, $time);
    end
  endtask

  // Reference model: a job is pending from acceptance until its result is
  // taken; it becomes available after W enabled clock edges.
  bit m_busy = 1'b0;
  int m_runs = 0;
  int m_last = 0;
  int q[$];
  bit acc_evt = 1'b0;
  bit res_evt = 1'b0;
  int ev_a = 0;
  int ev_b = 0;
  int n_acc = 0;
  int n_res = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  bit exp_done;

  // Model advance on each clock edge using events observed at the prior negedge.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_busy = 1'b0;
      m_runs = 0;
      m_last = 0;
      q.delete();
    end else if (ena) begin
      if (acc_evt) begin
        m_busy = 1'b1;
        m_runs = 0;
        q.push_back(ev_a * ev_b);
        n_acc++;
      end else if (m_busy && m_runs < W) begin
        m_runs++;
      end else if (res_evt) begin
        m_last = q.pop_front();
        m_busy = 1'b0;
        n_res++;
      end
    end
    acc_evt = 1'b0;
    res_evt = 1'b0;
  end

  // Compare DUT outputs against the model mid-cycle and record handshakes.
  always @(negedge clk) begin
    if (chk_en) begin
      exp_done = m_busy && (m_runs == W);
      chk("in_ready", int'(in_ready), int'(!m_busy && ena && !rst));
      chk("out_valid", int'(out_valid), int'(exp_done && ena && !rst));
      chk("busy", int'(busy), int'(m_busy));
      chk("product", int'(product), exp_done ? q[0] : m_last);
      if (in_valid && in_ready) begin
        acc_evt = 1'b1;
        ev_a = int'(a);
        ev_b = int'(b);
      end
      if (out_valid && out_ready) begin
        res_evt = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int av, input int bv, output int t);
    bit done = 1'b0;
    t = 0;
    a = W'(av);
    b = W'(bv);
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
        t = cyc;
      end
      step();
    end
    in_valid = 1'b0;
    if (!done) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_result(input int stall, input bit rnd, output int t);
    bit done = 1'b0;
    t = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      out_ready = (i >= stall) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
      @(negedge clk);
      if (out_valid && out_ready) begin
        done = 1'b1;
        t = cyc;
      end
      step();
    end
    out_ready = 1'b0;
    if (!done) chk("result_timeout", 0, 1);
  endtask

  int t0, t1;
  int ext_a[4] = '{15, 0, 9, 1};
  int ext_b[4] = '{15, 9, 0, 1};
  int ext_p[4] = '{225, 0, 0, 1};

  initial begin
    repeat (3) step();
    chk_en = 1'b1;
    chk("rst_product", int'(product), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    rst = 1'b0;
    step();
    chk("in_ready_after_rst", int'(in_ready), 1);

    // Basic 3*5 with out_ready held high.
    send(3, 5, t0);
    wait_result(0, 1'b0, t1);
    chk("basic_latency", t1 - t0, W + 1);
    chk("basic_product", int'(product), 15);
    chk("basic_in_ready", int'(in_ready), 1);

    // Extremes, each with exactly W run cycles.
    for (int k = 0; k < 4; k++) begin
      send(ext_a[k], ext_b[k], t0);
      wait_result(0, 1'b0, t1);
      chk("ext_latency", t1 - t0, W + 1);
      chk("ext_product", int'(product), ext_p[k]);
    end

    // Backpressure: hold out_ready low in DONE while offering new operands.
    send(7, 6, t0);
    repeat (6) step();
    a = 4'd1;
    b = 4'd1;
    in_valid = 1'b1;
    repeat (10) begin
      step();
      chk("bp_product", int'(product), 42);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    wait_result(0, 1'b0, t1);
    chk("bp_final_product", int'(product), 42);
    chk("bp_single_handshake", n_acc - n_res, 0);

    // Reset in the middle of a run.
    send(12, 11, t0);
    step();
    rst = 1'b1;
    step();
    chk("midrst_product", int'(product), 0);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    rst = 1'b0;
    step();
    chk("midrst_in_ready_after", int'(in_ready), 1);

    // Freeze for 5 cycles during RUN.
    send(13, 10, t0);
    step();
    step();
    ena = 1'b0;
    repeat (5) step();
    ena = 1'b1;
    wait_result(0, 1'b0, t1);
    chk("freeze_latency", t1 - t0, W + 1 + 5);
    chk("freeze_product", int'(product), 130);

    // All operand pairs plus random ones, with random result stalls.
    n_acc = 0;
    n_res = 0;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        send(i, j, t0);
        wait_result(0, 1'b1, t1);
      end
    end
    for (int k = 0; k < 20; k++) begin
      send(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), t0);
      wait_result(int'($urandom_range(0, 3)), 1'b1, t1);
    end
    step();
    chk("handshake_balance", n_res, n_acc);
    chk("accept_count", n_acc, 276);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
